// File: rtl/uart_image_loader.sv
// uart_image_loader
//   Receives 8N1 UART bytes (LSB first) and writes them as consecutive pixels
//   into an external image memory. After NUM_PIXELS bytes the frame is held
//   (image_ready) until the downstream network acknowledges it.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (>= 4)
//   NUM_PIXELS   : bytes per frame
//   ADDR_W       : pixel address width (2**ADDR_W >= NUM_PIXELS)
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous active-high reset
//   rx_serial    : asynchronous UART line, idle high
//   image_ack    : one-cycle pulse releasing a held frame
//   wr_en        : one-cycle pixel write strobe
//   wr_addr      : pixel index of the write
//   wr_data      : pixel byte of the write
//   image_ready  : level, a full frame is in memory
//   busy         : frame partially received
//   frame_error  : sticky, a stop bit was sampled low
//   overrun      : sticky, a byte arrived while a frame was held
module uart_image_loader #(
    parameter int CLKS_PER_BIT = 100,
    parameter int NUM_PIXELS   = 784,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_serial,
    input  logic              image_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              image_ready,
    output logic              busy,
    output logic              frame_error,
    output logic              overrun
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);

    // Terminal counts: the start bit is checked at its midpoint, every later
    // sample is one full bit period after the previous one.
    localparam logic [TIMER_W-1:0] HALF_LAST  = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LAST   = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0]  LAST_PIXEL = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t              state;
    logic                rx_meta;
    logic                rx_sync;
    logic [TIMER_W-1:0]  timer;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic [ADDR_W-1:0]   pix_idx;

    // Both synchronizer flops reset to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            pix_idx     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            image_ready <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            wr_en <= 1'b0;

            if (image_ack && image_ready)
                image_ready <= 1'b0;
            // Written after the ack clear so that completing a frame wins over
            // an ack on the same cycle; that ack saw image_ready low anyway.
            if (wr_en && (wr_addr == LAST_PIXEL))
                image_ready <= 1'b1;

            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (!rx_sync)
                        state <= START;
                end

                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state <= rx_sync ? IDLE : DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer          <= '0;
                        shift[bit_idx] <= rx_sync;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= CLEANUP;
                        // The write strobe is registered here so that it is
                        // high exactly during the single CLEANUP cycle.
                        if (!rx_sync) begin
                            frame_error <= 1'b1;
                        end else if (image_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix_idx;
                            wr_data <= shift;
                            pix_idx <= (pix_idx == LAST_PIXEL) ? '0 : pix_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                CLEANUP: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (pix_idx != '0) && !image_ready;

endmodule

// File: tb/tb_uart_image_loader.sv
// Self-checking bench for uart_image_loader (CLKS_PER_BIT=4, NUM_PIXELS=4).
// A frame-level reference model (pixel counter, ready/sticky flags, queue of
// expected writes) is updated per transmitted byte and compared against the
// writes and status observed from the DUT.
module tb_uart_image_loader;

    localparam int CPB = 4;
    localparam int NP  = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_serial;
    logic          image_ack;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          image_ready;
    logic          busy;
    logic          frame_error;
    logic          overrun;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_idx;
    bit          m_ready;
    bit          m_ferr;
    bit          m_ovr;
    logic [9:0]  exp_q[$];
    logic [9:0]  obs_q[$];

    uart_image_loader #(
        .CLKS_PER_BIT (CPB),
        .NUM_PIXELS   (NP),
        .ADDR_W       (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_serial   (rx_serial),
        .image_ack   (image_ack),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .image_ready (image_ready),
        .busy        (busy),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // collect every write strobe, sampled away from the rising edge
    always @(negedge clk) begin
        if (wr_en === 1'b1)
            obs_q.push_back({wr_addr, wr_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_ready = 0;
        m_ferr  = 0;
        m_ovr   = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            m_ferr = 1;
        end else if (m_ready) begin
            m_ovr = 1;
        end else begin
            exp_q.push_back({AW'(m_idx), b});
            m_idx = (m_idx + 1) % NP;
            if (m_idx == 0)
                m_ready = 1;
        end
    endtask

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        settle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
        drive_bit(stop_ok ? 1'b1 : 1'b0);
        rx_serial = 1'b1;
    endtask

    task automatic tx(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        send_byte(b, stop_ok);
    endtask

    task automatic pulse_ack();
        image_ack = 1'b1;
        settle(1);
        image_ack = 1'b0;
        if (m_ready)
            m_ready = 0;
    endtask

    task automatic check_writes(input string tag);
        logic [9:0] o;
        logic [9:0] e;
        chk({tag, "_wrcount"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_wraddr"}, o[9:8], e[9:8]);
            chk({tag, "_wrdata"}, o[7:0], e[7:0]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ready"}, image_ready, m_ready);
        chk({tag, "_busy"}, busy, (m_idx != 0) && !m_ready);
        chk({tag, "_ferr"}, frame_error, m_ferr);
        chk({tag, "_ovr"}, overrun, m_ovr);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wren"}, wr_en, 1'b0);
        chk({tag, "_wraddr"}, wr_addr, '0);
        chk({tag, "_wrdata"}, wr_data, 8'h00);
        chk({tag, "_ready"}, image_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ferr"}, frame_error, 1'b0);
        chk({tag, "_ovr"}, overrun, 1'b0);
    endtask

    initial begin
        int act;
        int n;
        logic [7:0] b;

        reset     = 1'b1;
        rx_serial = 1'b1;
        image_ack = 1'b0;
        model_reset();
        settle(3);
        check_all_zero("reset");
        reset = 1'b0;
        settle(4);

        // four back-to-back bytes fill the frame
        tx(8'h11, 1);
        tx(8'h22, 1);
        tx(8'h33, 1);
        tx(8'h44, 1);
        settle(8);
        check_writes("fill");
        check_state("fill");

        // byte while frame held -> overrun, then ack, then new frame starts
        tx(8'h55, 1);
        settle(8);
        check_writes("ovr");
        check_state("ovr");
        pulse_ack();
        settle(4);
        check_state("ack");
        tx(8'hA5, 1);
        settle(8);
        check_writes("after_ack");
        check_state("after_ack");

        // bad stop bit: no write, same address reused by the next good byte
        tx(8'h3C, 0);
        settle(8);
        check_writes("ferr");
        check_state("ferr");
        tx(8'h5A, 1);
        settle(8);
        check_writes("after_ferr");
        check_state("after_ferr");

        // one-cycle low glitch is ignored
        rx_serial = 1'b0;
        settle(1);
        rx_serial = 1'b1;
        settle(CPB * 3);
        check_writes("glitch");
        check_state("glitch");

        // asynchronous reset in the middle of a byte's data bits
        chk("pre_reset_busy", busy, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        rx_serial = 1'b1;
        settle(3);
        reset = 1'b0;
        settle(4);
        model_reset();
        obs_q.delete();
        tx(8'h81, 1);
        settle(8);
        check_writes("post_reset");
        check_state("post_reset");

        // ack on the same cycle as the final write is ignored
        tx(8'h01, 1);
        tx(8'h02, 1);
        model_byte(8'h03, 1);
        fork
            send_byte(8'h03, 1);
            begin
                n = 0;
                while (!(wr_en === 1'b1 && wr_addr == AW'(NP - 1)) && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("ack_window_found", n < 200, 1'b1);
                image_ack = 1'b1;
                @(posedge clk);
                #1;
                image_ack = 1'b0;
            end
        join
        settle(8);
        check_writes("ack_same");
        check_state("ack_same");
        settle(20);
        chk("ack_same_hold", image_ready, 1'b1);
        pulse_ack();
        settle(4);
        check_state("ack_release");

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            act = $urandom_range(0, 9);
            b   = 8'($urandom);
            if (act <= 5) begin
                tx(b, 1);
            end else if (act == 6) begin
                tx(b, 0);
            end else if (act == 7) begin
                pulse_ack();
            end else if (act == 8) begin
                rx_serial = 1'b0;
                settle(1);
                rx_serial = 1'b1;
            end else begin
                tx(b, 1);
                tx(8'($urandom), 1);
            end
            settle(8);
            check_writes("rnd");
            check_state("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
